// File: rtl/ll_fifo_pkg.sv
// Shared definitions for the linked-list fifo slice: parameter defaults and
// queue-id sizing used by the fifo and its drain stage.
package ll_fifo_pkg;

  localparam int unsigned WIDTH_DEF     = 8;
  localparam int unsigned NUM_FIFOS_DEF = 2;
  localparam int unsigned BURST_DEF     = 2;

  // Queue-id width; never below one bit so a 2-queue fifo still has a select.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned SEL_WIDTH_DEF = sel_width(NUM_FIFOS_DEF);

  typedef logic [SEL_WIDTH_DEF-1:0] qid_t;

endpackage

// File: rtl/ll_fifo_rr_drain_rr_arbiter.sv
// Combinational round-robin picker: first asserted request scanning upward
// from the pointer with wrap, reported as an encoded index plus a valid flag.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned SW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] ptr_i,
  output logic [SW-1:0] gnt_idx_o,
  output logic          any_o
);

  always_comb begin : scan
    int unsigned idx;
    logic        found;
    idx       = 0;
    found     = 1'b0;
    gnt_idx_o = ptr_i;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        found     = 1'b1;
        gnt_idx_o = SW'(idx);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/ll_fifo_rr_drain.sv
// Drain stage for the shared linked-list fifo: round-robin pops with a
// per-queue burst limit into a 2-entry skid buffer feeding a valid/ready stream.
module ll_fifo_rr_drain
  import ll_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned NUM_FIFOS = NUM_FIFOS_DEF,
  parameter int unsigned BURST     = BURST_DEF,
  parameter int unsigned SEL_WIDTH = sel_width(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FIFOS-1:0] fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 pop,
  output logic [SEL_WIDTH-1:0] pop_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_qid
);

  localparam int unsigned CNT_W = $clog2(BURST + 1);

  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d, grant;
  logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d, consec;
  logic [1:0]           count_q, count_d;
  logic [WIDTH-1:0]     data_q [2];
  logic [WIDTH-1:0]     data_d [2];
  logic [SEL_WIDTH-1:0] qid_q  [2];
  logic [SEL_WIDTH-1:0] qid_d  [2];
  logic                 any_req, space, deq, wr_slot;

  rr_arbiter #(.N(NUM_FIFOS), .SW(SEL_WIDTH)) u_arb (
    .req_i    (~fifo_empty),
    .ptr_i    (rr_ptr_q),
    .gnt_idx_o(grant),
    .any_o    (any_req)
  );

  assign space     = (count_q != 2'd2);
  assign pop       = !rst && space && any_req;
  assign pop_sel   = pop ? grant : rr_ptr_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = data_q[0];
  assign out_qid   = qid_q[0];
  assign deq       = out_valid && out_ready;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    consec      = (grant == rr_ptr_q) ? burst_cnt_q + CNT_W'(1) : CNT_W'(1);
    if (pop) begin
      if (consec == CNT_W'(BURST)) begin
        rr_ptr_d    = (grant == SEL_WIDTH'(NUM_FIFOS - 1)) ? '0 : grant + SEL_WIDTH'(1);
        burst_cnt_d = '0;
      end else begin
        rr_ptr_d    = grant;
        burst_cnt_d = consec;
      end
    end
  end

  // Dequeue shifts entry 1 down; a push lands in slot 1 only when an entry stays behind.
  always_comb begin
    data_d  = data_q;
    qid_d   = qid_q;
    wr_slot = (count_q == 2'd1) && !deq;
    if (deq) begin
      data_d[0] = data_q[1];
      qid_d[0]  = qid_q[1];
    end
    if (pop) begin
      data_d[wr_slot] = fifo_data;
      qid_d[wr_slot]  = grant;
    end
    count_d = count_q + 2'(pop) - 2'(deq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      count_q     <= '0;
      data_q[0]   <= '0;
      data_q[1]   <= '0;
      qid_q[0]    <= '0;
      qid_q[1]    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      count_q     <= count_d;
      data_q      <= data_d;
      qid_q       <= qid_d;
    end
  end

`ifdef FORMAL
  always_comb begin
    if (pop) assert (!fifo_empty[pop_sel]);
    assert (count_q <= 2'd2);
    assert (out_valid == (count_q != 2'd0));
    assert (32'(rr_ptr_q) < NUM_FIFOS);
    assert (32'(burst_cnt_q) < BURST);
  end
`endif

endmodule

// File: tb/tb_ll_fifo_rr_drain.sv
// Directed bench for ll_fifo_rr_drain: queue-level model of the shared fifo and
// drain stage checked every cycle, plus hand-computed pop/output sequences.
module tb_ll_fifo_rr_drain;

  localparam int NF = 2;
  localparam int BR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] fifo_empty = 2'b00;
  logic [7:0] fifo_data = 8'h00;
  logic       pop;
  logic [0:0] pop_sel;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [0:0] out_qid;

  ll_fifo_rr_drain #(.WIDTH(8), .NUM_FIFOS(NF), .BURST(BR)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .pop       (pop),
    .pop_sel   (pop_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_qid   (out_qid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Environment queues and model of the drain stage.
  int mq [NF][$];
  int bd [$];
  int bq [$];
  int mptr = 0;
  int mbc  = 0;
  int plog [$];
  int olog [$];
  int e    [$];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic chk_seq(input string n, input int act[$], input int exp[$]);
    chk({n, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      chk(n, act[i], exp[i]);
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic step(input bit r, input bit rdy);
    int  g;
    int  esel;
    int  consec;
    bit  epop;
    bit  evalid;
    g = -1;
    for (int k = 0; k < NF; k++) begin
      int idx;
      idx = (mptr + k) % NF;
      if (g < 0 && mq[idx].size() > 0) g = idx;
    end
    evalid = (bd.size() != 0);
    epop   = !r && (bd.size() < 2) && (g >= 0);
    esel   = epop ? g : mptr;
    rst       = r;
    out_ready = rdy;
    for (int i = 0; i < NF; i++) fifo_empty[i] = (mq[i].size() == 0);
    fifo_data = epop ? 8'(mq[g][0]) : 8'h00;
    #1;
    chk("pop", int'(pop), int'(epop));
    if (!r) begin
      chk("pop_sel", int'(pop_sel), esel);
      chk("out_valid", int'(out_valid), int'(evalid));
      if (evalid) begin
        chk("out_data", int'(out_data), bd[0]);
        chk("out_qid", int'(out_qid), bq[0]);
      end
    end
    if (r) begin
      bd.delete();
      bq.delete();
      mptr = 0;
      mbc  = 0;
    end else begin
      if (evalid && rdy) begin
        olog.push_back(bd.pop_front());
        void'(bq.pop_front());
      end
      if (epop) begin
        plog.push_back(g);
        bd.push_back(mq[g].pop_front());
        bq.push_back(g);
        consec = (g == mptr) ? mbc + 1 : 1;
        if (consec == BR) begin
          mptr = (g + 1) % NF;
          mbc  = 0;
        end else begin
          mptr = g;
          mbc  = consec;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    plog.delete();
    olog.delete();
  endtask

  initial begin
    // Reset with both queues non-empty; first cycle out of reset pops queue 0.
    mq[0] = '{8'h01, 8'h02};
    mq[1] = '{8'h03};
    do_reset();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_qid", int'(out_qid), 0);
    repeat (5) step(1'b0, 1'b1);
    e = '{0, 0, 1};           chk_seq("t1_popsel", plog, e);
    e = '{8'h01, 8'h02, 8'h03}; chk_seq("t1_out", olog, e);

    // Burst of two per queue with both queues busy.
    do_reset();
    mq[0] = '{8'h10, 8'h11, 8'h12, 8'h13};
    mq[1] = '{8'h20, 8'h21, 8'h22, 8'h23};
    repeat (10) step(1'b0, 1'b1);
    e = '{0, 0, 1, 1, 0, 0, 1, 1}; chk_seq("t2_popsel", plog, e);
    e = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
    chk_seq("t2_out", olog, e);

    // Only queue 0 has data.
    do_reset();
    mq[0] = '{8'hAA, 8'hBB, 8'hCC};
    repeat (5) step(1'b0, 1'b1);
    e = '{0, 0, 0};             chk_seq("t3_popsel", plog, e);
    e = '{8'hAA, 8'hBB, 8'hCC}; chk_seq("t3_out", olog, e);

    // Backpressure: two pops fill the buffer, then stall with 8'h11 held.
    do_reset();
    mq[0] = '{8'h11, 8'h22, 8'h44};
    repeat (4) step(1'b0, 1'b0);
    e = '{0, 0}; chk_seq("t4_stall_popsel", plog, e);
    chk("t4_held_data", int'(out_data), 8'h11);
    chk("t4_no_pop", int'(pop), 0);
    repeat (4) step(1'b0, 1'b1);
    e = '{0, 0, 0};             chk_seq("t4_popsel", plog, e);
    e = '{8'h11, 8'h22, 8'h44}; chk_seq("t4_out", olog, e);

    // Queue 0 drains after one pop; burst count restarts at 1 for queue 1.
    do_reset();
    mq[0] = '{8'h50};
    mq[1] = '{8'h60, 8'h61, 8'h62};
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    mq[0].push_back(8'h51);
    repeat (5) step(1'b0, 1'b1);
    e = '{0, 1, 1, 0, 1};                     chk_seq("t5_popsel", plog, e);
    e = '{8'h50, 8'h60, 8'h61, 8'h51, 8'h62}; chk_seq("t5_out", olog, e);

    // Reset with a full buffer and pointer on queue 1: buffered words are lost.
    do_reset();
    mq[0] = '{8'h70, 8'h71, 8'h72, 8'h73};
    mq[1] = '{8'h80, 8'h81};
    repeat (3) step(1'b0, 1'b0);
    chk("t6_full_valid", int'(out_valid), 1);
    step(1'b1, 1'b0);
    chk("t6_rst_valid", int'(out_valid), 0);
    plog.delete();
    olog.delete();
    repeat (6) step(1'b0, 1'b1);
    e = '{0, 0, 1, 1};                 chk_seq("t6_popsel", plog, e);
    e = '{8'h72, 8'h73, 8'h80, 8'h81}; chk_seq("t6_out", olog, e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
